// File: rtl/rot_pkg.sv
// rtl/rot_pkg.sv - shared phase encodings, FSM states and quadrature step decode
package rot_pkg;

  // Phase encodings {A, B}; clockwise order is 00 -> 10 -> 11 -> 01 -> 00
  typedef enum logic [1:0] {
    AB_00 = 2'b00,
    AB_10 = 2'b10,
    AB_11 = 2'b11,
    AB_01 = 2'b01
  } ab_t;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } rot_state_t;

  typedef logic signed [1:0] step_t;

  localparam step_t STEP_NONE = 2'sb00;
  localparam step_t STEP_CW   = 2'sb01;
  localparam step_t STEP_CCW  = 2'sb11;

  // Both phases flipping at once skips a quadrature state, so direction is unknown
  function automatic logic ab_illegal(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    return (prev_ab ^ cur_ab) == 2'b11;
  endfunction

  // Single-bit transitions map to +1 (clockwise) or -1 (counter-clockwise)
  function automatic step_t ab_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    step_t step;
    case ({prev_ab, cur_ab})
      {AB_00, AB_10}, {AB_10, AB_11}, {AB_11, AB_01}, {AB_01, AB_00}: step = STEP_CW;
      {AB_10, AB_00}, {AB_11, AB_10}, {AB_01, AB_11}, {AB_00, AB_01}: step = STEP_CCW;
      default: step = STEP_NONE;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/rot_phase_filter.sv
// rtl/rot_phase_filter.sv - 2-FF synchroniser plus stability filter for one encoder phase
module rot_phase_filter #(
  parameter int FILTER_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic filt_o
);

  localparam int              CNT_W    = $clog2(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             filt_q;
  logic             filt_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Two-stage synchroniser; idles high to match the pulled-up encoder pins
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive mismatches; adopt the new level only after FILTER_CYCLES of them
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Filtered level and mismatch counter
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/rotary_quad_decoder.sv
// rtl/rotary_quad_decoder.sv - debounced quadrature decoder, one pulse per detent; ROT_ERR_DETECT_EN enables rot_err
module rotary_quad_decoder #(
  parameter int FILTER_CYCLES   = 1000,
  parameter int STEPS_PER_EVENT = 4,
  parameter int ACC_W           = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rot_a,
  input  logic rot_b,
  output logic rot_event,
  output logic rot_right,
  output logic rot_err
);

  import rot_pkg::*;

  localparam int                      INIT_W     = $clog2(FILTER_CYCLES + 3);
  localparam logic [INIT_W-1:0]       INIT_LAST  = INIT_W'(FILTER_CYCLES + 2);
  localparam logic signed [ACC_W-1:0] THRESH_POS = ACC_W'(STEPS_PER_EVENT);
  localparam logic signed [ACC_W-1:0] THRESH_NEG = ACC_W'(-STEPS_PER_EVENT);

  logic                    filt_a;
  logic                    filt_b;
  logic [1:0]              ab;
  step_t                   step;
  logic                    illegal;
  logic signed [ACC_W-1:0] acc_sum;

  rot_state_t              state_q;
  logic [INIT_W-1:0]       init_cnt_q;
  logic [1:0]              prev_ab_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    rot_event_q;
  logic                    rot_right_q;

  rot_phase_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
    .clk    (clk),
    .reset  (reset),
    .pin_i  (rot_a),
    .filt_o (filt_a)
  );

  rot_phase_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
    .clk    (clk),
    .reset  (reset),
    .pin_i  (rot_b),
    .filt_o (filt_b)
  );

  assign ab      = {filt_a, filt_b};
  assign step    = ab_step(prev_ab_q, ab);
  assign illegal = ab_illegal(prev_ab_q, ab);
  assign acc_sum = acc_q + ACC_W'(step);

`ifdef ROT_ERR_DETECT_EN
  logic rot_err_q;
`endif

  // INIT lets the filters settle after reset; TRACK accumulates steps and fires detent events
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      prev_ab_q   <= AB_11;
      acc_q       <= '0;
      rot_event_q <= 1'b0;
      rot_right_q <= 1'b0;
`ifdef ROT_ERR_DETECT_EN
      rot_err_q   <= 1'b0;
`endif
    end else begin
      rot_event_q <= 1'b0;
`ifdef ROT_ERR_DETECT_EN
      rot_err_q   <= 1'b0;
`endif
      case (state_q)
        INIT: begin
          if (init_cnt_q == INIT_LAST) begin
            prev_ab_q <= ab;
            state_q   <= TRACK;
          end else begin
            init_cnt_q <= init_cnt_q + INIT_W'(1);
          end
        end
        TRACK: begin
          prev_ab_q <= ab;
          if (illegal) begin
            acc_q <= '0;
`ifdef ROT_ERR_DETECT_EN
            rot_err_q <= 1'b1;
`endif
          end else if (acc_sum == THRESH_POS) begin
            acc_q       <= '0;
            rot_event_q <= 1'b1;
            rot_right_q <= 1'b1;
          end else if (acc_sum == THRESH_NEG) begin
            acc_q       <= '0;
            rot_event_q <= 1'b1;
            rot_right_q <= 1'b0;
          end else begin
            acc_q <= acc_sum;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign rot_event = rot_event_q;
  assign rot_right = rot_right_q;

`ifdef ROT_ERR_DETECT_EN
  assign rot_err = rot_err_q;
`else
  assign rot_err = 1'b0;
`endif

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// tb/tb_rotary_quad_decoder.sv - scoreboard bench for rotary_quad_decoder against a detent-level model
module tb_rotary_quad_decoder;

  localparam int FC  = 4;
  localparam int SPE = 4;
  localparam int LAT = FC + 3;

  logic clk = 1'b0;
  logic reset;
  logic rot_a;
  logic rot_b;
  logic rot_event;
  logic rot_right;
  logic rot_err;

  rotary_quad_decoder #(
    .FILTER_CYCLES   (FC),
    .STEPS_PER_EVENT (SPE),
    .ACC_W           (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rot_a     (rot_a),
    .rot_b     (rot_b),
    .rot_event (rot_event),
    .rot_right (rot_right),
    .rot_err   (rot_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: encoder position, step accumulator, expected-output queues
  logic [1:0] pins_m;
  int         acc_m;
  logic       exp_right;
  int         init_lo;
  int         init_hi;
  bit         mon_en;
  int         ev_cyc_q[$];
  logic       ev_dir_q[$];
  int         err_cyc_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Position of a phase code around the clockwise circle
  function automatic int quad_pos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] quad_code(input int p);
    case (((p % 4) + 4) % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // Drive a new pin level and predict what the decoder must report LAT cycles later
  task automatic drive(input logic [1:0] v);
    int d;
    @(negedge clk);
    {rot_a, rot_b} = v;
    d = (quad_pos(v) - quad_pos(pins_m) + 4) % 4;
    pins_m = v;
    if (d == 1) begin
      acc_m++;
    end else if (d == 3) begin
      acc_m--;
    end else if (d == 2) begin
      acc_m = 0;
`ifdef ROT_ERR_DETECT_EN
      err_cyc_q.push_back(cyc + LAT);
`endif
    end
    if (acc_m == SPE || acc_m == -SPE) begin
      ev_cyc_q.push_back(cyc + LAT);
      ev_dir_q.push_back(acc_m > 0);
      acc_m = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic move(input logic [1:0] v, input int hold);
    drive(v);
    idle(hold);
  endtask

  // Pulse one phase for fewer than FC cycles; the filter must swallow it
  task automatic bounce(input int phase, input int w);
    @(negedge clk);
    if (phase == 0) rot_a = ~pins_m[1];
    else            rot_b = ~pins_m[0];
    repeat (w) @(negedge clk);
    {rot_a, rot_b} = pins_m;
    idle(FC + 2);
  endtask

  task automatic do_reset();
    idle(LAT + 2);
    @(negedge clk);
    reset = 1'b1;
    ev_cyc_q.delete();
    ev_dir_q.delete();
    err_cyc_q.delete();
    acc_m     = 0;
    exp_right = 1'b0;
    init_lo   = cyc + 1;
    init_hi   = cyc + 1 + LAT;
    @(negedge clk);
    reset = 1'b0;
    idle(FC + 6);
  endtask

  // Monitor: compare DUT outputs against the scoreboard every cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (cyc >= init_lo && cyc <= init_hi) begin
          check("init_event", rot_event, 0);
          check("init_right", rot_right, 0);
          check("init_err", rot_err, 0);
        end
        if (ev_cyc_q.size() > 0 && ev_cyc_q[0] == cyc) begin
          check("event_pulse", rot_event, 1);
          check("event_dir", rot_right, ev_dir_q[0]);
          exp_right = ev_dir_q[0];
          void'(ev_cyc_q.pop_front());
          void'(ev_dir_q.pop_front());
        end else begin
          check("no_event", rot_event, 0);
          check("right_hold", rot_right, exp_right);
        end
`ifdef ROT_ERR_DETECT_EN
        if (err_cyc_q.size() > 0 && err_cyc_q[0] == cyc) begin
          check("err_pulse", rot_err, 1);
          void'(err_cyc_q.pop_front());
        end else begin
          check("no_err", rot_err, 0);
        end
`else
        check("err_tied", rot_err, 0);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    rot_a     = 1'b1;
    rot_b     = 1'b1;
    pins_m    = 2'b11;
    acc_m     = 0;
    exp_right = 1'b0;
    mon_en    = 1'b0;
    init_lo   = 0;
    init_hi   = 0;
    repeat (3) @(negedge clk);
    check("reset_event", rot_event, 0);
    check("reset_right", rot_right, 0);
    check("reset_err", rot_err, 0);
    init_lo = cyc;
    init_hi = cyc + LAT;
    mon_en  = 1'b1;
    reset   = 1'b0;
    idle(FC + 6);

    // Clockwise detent
    move(2'b01, 20); move(2'b00, 20); move(2'b10, 20); move(2'b11, 20);
    // Counter-clockwise detent
    move(2'b10, 20); move(2'b00, 20); move(2'b01, 20); move(2'b11, 20);
    // Bounce on both phases, widths up to FC-1
    bounce(0, 2); bounce(0, 2); bounce(1, 1); bounce(1, FC - 1);
    // Reversal mid-detent returns to zero, then a full detent is still needed
    move(2'b01, 12); move(2'b00, 12); move(2'b01, 12); move(2'b11, 12);
    move(2'b01, 12); move(2'b00, 12); move(2'b10, 12); move(2'b11, 12);
    // Illegal double-bit jumps
    move(2'b00, 12); move(2'b11, 12);
    // Reset mid-detent, then a full detent from where the encoder sits
    move(2'b01, 12); move(2'b00, 12);
    do_reset();
    move(2'b10, 12); move(2'b11, 12); move(2'b01, 12); move(2'b00, 12);

    // Randomised walk
    for (int i = 0; i < 300; i++) begin
      int op;
      int hold;
      op   = $urandom_range(0, 39);
      hold = $urandom_range(FC + 2, FC + 12);
      if (op < 16)      move(quad_code(quad_pos(pins_m) + 1), hold);
      else if (op < 30) move(quad_code(quad_pos(pins_m) + 3), hold);
      else if (op < 35) bounce($urandom_range(0, 1), $urandom_range(1, FC - 1));
      else if (op < 38) move(pins_m ^ 2'b11, hold);
      else if (op < 39) idle(hold);
      else              do_reset();
    end

    idle(LAT + 5);
    check("events_outstanding", ev_cyc_q.size(), 0);
    check("errs_outstanding", err_cyc_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
